// File: rtl/vmm_pkg.sv
// vmm_pkg: types and defaults shared by the VMM datapath blocks
//   state_t    : sequencer state encoding (IDLE, SHIFT, DONE)
//   DEF_WIDTH  : default operand/result width
package vmm_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: bit-serial full adder with a registered carry
//   clk, rst          : clock, async active-high reset
//   a, b              : operand bits for this cycle
//   cin_load, cin_val : overwrite the carry flop with cin_val
//   en                : advance the carry by one bit position
//   s                 : combinational sum bit of a, b and the stored carry
//   cout              : stored carry
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin_load,
    input  logic cin_val,
    input  logic en,
    output logic s,
    output logic cout
);
    logic c;
    always_ff @(posedge clk or posedge rst)
        if (rst) c <= 1'b0;
        else if (cin_load) c <= cin_val;
        else if (en) c <= (a & b) | (a & c) | (b & c);
    assign s    = a ^ b ^ c;
    assign cout = c;
endmodule

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: LSB-first bit-serial add/sub sequencer with valid/ready ends
//   clk, rst                          : clock, async active-high reset
//   in_valid/in_ready, op_a, op_b, sub : operand pair handshake (sub=1: A-B)
//   abort                             : cancel the operation in flight
//   busy                              : high while bits are being processed
//   out_valid/out_ready               : result handshake
//   result, carry_out, ovf            : sum/difference, final carry, signed overflow
module serial_addsub_seq import vmm_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CNT_W-1:0] cnt;
    logic msb_a, msb_b_eff, accept, last, step, s_bit;
    assign accept = (state == IDLE) & in_valid & ~abort;
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign step   = (state == SHIFT) & ~abort;
    // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with sub.
    // An abort outside IDLE reloads the carry with 0 to clear it.
    serial_fa_cell u_fa (
        .clk      (clk),
        .rst      (rst),
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .cin_load (accept | (abort & (state != IDLE))),
        .cin_val  (accept & sub),
        .en       (step),
        .s        (s_bit),
        .cout     (carry_out)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt       = state;
        in_ready  = state == IDLE;
        busy      = state == SHIFT;
        out_valid = state == DONE;
        case (state)
            IDLE:    nxt = accept ? SHIFT : IDLE;
            SHIFT:   nxt = abort ? IDLE : (last ? DONE : SHIFT);
            DONE:    nxt = (abort | out_ready) ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            msb_a     <= 1'b0;
            msb_b_eff <= 1'b0;
        end else if (accept) begin
            a_sh      <= op_a;
            b_sh      <= op_b ^ {WIDTH{sub}};
            cnt       <= '0;
            msb_a     <= op_a[WIDTH-1];
            msb_b_eff <= op_b[WIDTH-1] ^ sub;
        end else if (step) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {s_bit, res[WIDTH-1:1]};
            if (!last) cnt <= cnt + CNT_W'(1);
        end
    assign result = res;
    assign ovf    = (msb_a == msb_b_eff) & (res[WIDTH-1] != msb_a);
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: table + scoreboard bench for serial_addsub_seq (WIDTH=8)
module tb_serial_addsub_seq;
    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
    } exp_t;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk = 0, rst = 1, in_valid = 0, sub = 0, abort = 0, out_ready = 1;
    logic [7:0] op_a = 0, op_b = 0;
    logic in_ready, busy, out_valid, carry_out, ovf;
    logic [7:0] result;
    int total = 0, bad = 0, cyc = 0;
    exp_t q[$];

    serial_addsub_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .abort(abort), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t m;
        int sa, sb, r, ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r = s ? sa - sb : sa + sb;
        m.ov  = (r > 127) || (r < -128);
        m.res = s ? 8'(ua - ub) : 8'(ua + ub);
        m.co  = s ? (ua >= ub) : (ua + ub > 255);
        return m;
    endfunction

    // scoreboard: pop and compare on every result handshake; sampled after the negedge
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: result %0h with no pending operation", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("carry_out", 64'(carry_out), 64'(e.co));
                chk("ovf", 64'(ovf), 64'(e.ov));
            end
        end
    end

    // called at a negedge; returns at the negedge after the accept edge with in_valid dropped
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic push, input exp_t e, output int acc);
        int n = 0;
        in_valid = 1; op_a = a; op_b = b; sub = s;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        acc = cyc + 1;
        if (push) q.push_back(e);
        @(negedge clk);
        in_valid = 0;
        op_a = $urandom; op_b = $urandom; sub = $urandom;
    endtask

    task automatic wait_done(input int acc);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(cyc - acc), 64'(8));
    endtask

    initial begin
        vec_t tab[6];
        exp_t e;
        int acc, prev;
        tab[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
        tab[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tab[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tab[3] = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
        tab[4] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        tab[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            e = '{tab[i].res, tab[i].co, tab[i].ov};
            send(tab[i].a, tab[i].b, tab[i].s, 1'b1, e, acc);
            chk("busy_in_shift", 64'(busy), 64'(1));
            wait_done(acc);
            @(negedge clk);
        end
        // output stall in DONE with noisy inputs
        out_ready = 0;
        send(8'h35, 8'h1A, 1'b0, 1'b1, '{8'h4F, 1'b0, 1'b0}, acc);
        wait_done(acc);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; op_a = $urandom;
            @(negedge clk);
            chk("hold_result", 64'(result), 64'(8'h4F));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("release_idle", 64'({in_ready, out_valid}), 64'(2'b10));
        prev = cyc;
        send(8'h01, 8'h02, 1'b0, 1'b1, '{8'h03, 1'b0, 1'b0}, acc);
        chk("accept_after_release", 64'(acc - prev), 64'(1));
        wait_done(acc);
        @(negedge clk);
        // reset at bit 4
        send(8'h35, 8'h1A, 1'b0, 1'b0, e, acc);
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_state", 64'({in_ready, busy, out_valid}), 64'(3'b100));
        chk("midrst_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        // abort at bit 3
        send(8'hFF, 8'hFF, 1'b0, 1'b0, e, acc);
        repeat (2) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_state", 64'({in_ready, busy, out_valid}), 64'(3'b100));
        chk("abort_carry", 64'(carry_out), 64'(0));
        // abort beats acceptance in IDLE
        abort = 1; in_valid = 1;
        @(negedge clk);
        chk("abort_idle_no_accept", 64'({in_ready, busy}), 64'(2'b10));
        abort = 0; in_valid = 0;
        send(8'h01, 8'h01, 1'b0, 1'b1, '{8'h02, 1'b0, 1'b0}, acc);
        wait_done(acc);
        @(negedge clk);
        // back-to-back random traffic
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, b;
            logic s;
            a = $urandom; b = $urandom; s = $urandom;
            send(a, b, s, 1'b1, model(a, b, s), acc);
            if (i > 0) chk("init_interval", 64'(acc - prev), 64'(10));
            prev = acc;
        end
        for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
